// File: rtl/db_table_ctrl.sv
// Command front-end for the hash-table RAM: GET/SET/DEL against one slot per command,
// one read, an optional write-back, one response, and GET hit/miss statistics.
module db_table_ctrl #(
    parameter  int ADDR_WIDTH = 12,
    parameter  int TAG_WIDTH  = 16,
    parameter  int VAL_WIDTH  = 31,
    localparam int DATA_WIDTH = 1 + TAG_WIDTH + VAL_WIDTH
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [1:0]              in_op,
    input  logic [ADDR_WIDTH-1:0]   in_index,
    input  logic [TAG_WIDTH-1:0]    in_tag,
    input  logic [VAL_WIDTH-1:0]    in_value,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [1:0]              out_op,
    output logic                    out_hit,
    output logic                    out_evict,
    output logic                    out_err,
    output logic [VAL_WIDTH-1:0]    out_value,
    output logic [ADDR_WIDTH-1:0]   mem_raddr,
    output logic                    mem_rd_en,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    input  logic                    mem_rvalid,
    output logic [ADDR_WIDTH-1:0]   mem_waddr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wmask,
    output logic                    mem_wr_en,
    output logic [31:0]             cnt_hit,
    output logic [31:0]             cnt_miss
);

    localparam logic [1:0] OP_GET = 2'b00;
    localparam logic [1:0] OP_SET = 2'b01;
    localparam logic [1:0] OP_DEL = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WAIT,
        RESP
    } state_t;

    state_t                 state;
    state_t                 next_state;

    logic [1:0]             op_q;
    logic [ADDR_WIDTH-1:0]  index_q;
    logic [TAG_WIDTH-1:0]   tag_q;
    logic [VAL_WIDTH-1:0]   value_q;
    logic                   wr_en_q;
    logic [DATA_WIDTH-1:0]  wdata_q;

    logic                   accept;
    logic                   slot_valid;
    logic [TAG_WIDTH-1:0]   slot_tag;
    logic [VAL_WIDTH-1:0]   slot_value;
    logic                   match;

    assign accept     = in_valid && in_ready;
    assign slot_valid = mem_rdata[DATA_WIDTH-1];
    assign slot_tag   = mem_rdata[DATA_WIDTH-2 -: TAG_WIDTH];
    assign slot_value = mem_rdata[VAL_WIDTH-1:0];
    assign match      = slot_valid && (slot_tag == tag_q);

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == RESP);
    assign mem_rd_en = (state == RD);
    assign mem_raddr = index_q;
    assign mem_waddr = index_q;
    assign mem_wdata = wdata_q;
    assign mem_wr_en = wr_en_q;
    assign mem_wmask = '0;

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Reserved opcodes never touch the RAM and answer straight away.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = (in_op == OP_RSV) ? RESP : RD;
                end
            end
            RD: begin
                next_state = WAIT;
            end
            WAIT: begin
                if (mem_rvalid) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // The write strobe is armed on entry to RESP and self-clears, so a stalled
    // response never repeats the write.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            op_q      <= '0;
            index_q   <= '0;
            tag_q     <= '0;
            value_q   <= '0;
            out_op    <= '0;
            out_hit   <= 1'b0;
            out_evict <= 1'b0;
            out_err   <= 1'b0;
            out_value <= '0;
            wr_en_q   <= 1'b0;
            wdata_q   <= '0;
            cnt_hit   <= '0;
            cnt_miss  <= '0;
        end else begin
            wr_en_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q    <= in_op;
                        index_q <= in_index;
                        tag_q   <= in_tag;
                        value_q <= in_value;
                        if (in_op == OP_RSV) begin
                            out_op    <= in_op;
                            out_hit   <= 1'b0;
                            out_evict <= 1'b0;
                            out_err   <= 1'b1;
                            out_value <= '0;
                        end
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        out_op    <= op_q;
                        out_err   <= 1'b0;
                        out_hit   <= match;
                        out_evict <= (op_q == OP_SET) && slot_valid && !match;
                        out_value <= ((op_q == OP_GET) && match) ? slot_value : '0;
                        wr_en_q   <= (op_q == OP_SET) || ((op_q == OP_DEL) && match);
                        wdata_q   <= (op_q == OP_SET) ? {1'b1, tag_q, value_q} : '0;
                        if (op_q == OP_GET) begin
                            if (match) begin
                                cnt_hit <= cnt_hit + 32'd1;
                            end else begin
                                cnt_miss <= cnt_miss + 32'd1;
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_db_table_ctrl.sv
// Bench for db_table_ctrl: a RAM model with variable latency plus a slot-table
// reference model; directed scenarios followed by randomized commands.
module tb_db_table_ctrl;

    localparam int AW = 12;
    localparam int TW = 16;
    localparam int VW = 31;
    localparam int DW = 48;

    logic          sys_clk = 1'b0;
    logic          sys_rst;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_op;
    logic [AW-1:0] in_index;
    logic [TW-1:0] in_tag;
    logic [VW-1:0] in_value;
    logic          out_valid;
    logic          out_ready;
    logic [1:0]    out_op;
    logic          out_hit;
    logic          out_evict;
    logic          out_err;
    logic [VW-1:0] out_value;
    logic [AW-1:0] mem_raddr;
    logic          mem_rd_en;
    logic [DW-1:0] mem_rdata;
    logic          mem_rvalid;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic [DW/8-1:0] mem_wmask;
    logic          mem_wr_en;
    logic [31:0]   cnt_hit;
    logic [31:0]   cnt_miss;

    int tests_run    = 0;
    int tests_failed = 0;

    db_table_ctrl dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_index   (in_index),
        .in_tag     (in_tag),
        .in_value   (in_value),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_op     (out_op),
        .out_hit    (out_hit),
        .out_evict  (out_evict),
        .out_err    (out_err),
        .out_value  (out_value),
        .mem_raddr  (mem_raddr),
        .mem_rd_en  (mem_rd_en),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .mem_wmask  (mem_wmask),
        .mem_wr_en  (mem_wr_en),
        .cnt_hit    (cnt_hit),
        .cnt_miss   (cnt_miss)
    );

    always #5 sys_clk = ~sys_clk;

    // RAM model: read data returns ram_lat+1 cycles after the strobe; spur injects stray rvalid.
    logic [DW-1:0] ram [0:4095];
    int            ram_lat = 0;
    logic          spur = 1'b0;
    int            lat_cnt;
    logic [AW-1:0] lat_addr;

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = '0;
    end

    always @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            mem_rvalid <= 1'b0;
            mem_rdata  <= '0;
            lat_cnt    <= 0;
            lat_addr   <= '0;
        end else begin
            mem_rvalid <= 1'b0;
            if (mem_wr_en) ram[mem_waddr] <= mem_wdata;
            if (mem_rd_en) begin
                if (ram_lat == 0) begin
                    mem_rvalid <= 1'b1;
                    mem_rdata  <= ram[mem_raddr];
                end else begin
                    lat_cnt  <= ram_lat;
                    lat_addr <= mem_raddr;
                end
            end else if (lat_cnt != 0) begin
                lat_cnt <= lat_cnt - 1;
                if (lat_cnt == 1) begin
                    mem_rvalid <= 1'b1;
                    mem_rdata  <= ram[lat_addr];
                end
            end else if (spur) begin
                mem_rvalid <= 1'b1;
                mem_rdata  <= {16'($urandom), $urandom};
            end
        end
    end

    // Reference model of the table contents and statistics.
    bit            m_valid [4096];
    logic [TW-1:0] m_tag   [4096];
    logic [VW-1:0] m_val   [4096];
    logic [31:0]   m_hits   = 0;
    logic [31:0]   m_misses = 0;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check_output(input string name, input logic [63:0] observed, input logic [63:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", name, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [1:0] op, input logic [AW-1:0] idx,
                                  input logic [TW-1:0] tag, input logic [VW-1:0] val,
                                  input int hold, input int lat);
        bit            match;
        logic          e_hit, e_evict, e_err, e_wr;
        logic [VW-1:0] e_val;
        logic [DW-1:0] e_wdata;
        int            e_lat;
        int            waited, cyc, rd_cnt, rd_at, wr_cnt;
        logic [DW-1:0] got_wdata;
        logic [AW-1:0] got_waddr;
        logic          ready_low, stable;
        logic [1:0]    s_op;
        logic          s_hit, s_evict, s_err;
        logic [VW-1:0] s_val;

        match   = m_valid[idx] && (m_tag[idx] == tag);
        e_hit   = 1'b0;
        e_evict = 1'b0;
        e_err   = 1'b0;
        e_wr    = 1'b0;
        e_val   = '0;
        e_wdata = '0;
        case (op)
            2'b00: begin
                e_hit = match;
                e_val = match ? m_val[idx] : '0;
                if (match) m_hits = m_hits + 1;
                else       m_misses = m_misses + 1;
            end
            2'b01: begin
                e_hit      = match;
                e_evict    = m_valid[idx] && !match;
                e_wr       = 1'b1;
                e_wdata    = {1'b1, tag, val};
                m_valid[idx] = 1'b1;
                m_tag[idx]   = tag;
                m_val[idx]   = val;
            end
            2'b10: begin
                e_hit = match;
                if (match) begin
                    e_wr         = 1'b1;
                    m_valid[idx] = 1'b0;
                    m_tag[idx]   = '0;
                    m_val[idx]   = '0;
                end
            end
            default: e_err = 1'b1;
        endcase
        e_lat = (op == 2'b11) ? 1 : 3 + lat;

        ram_lat = lat;
        @(negedge sys_clk);
        in_valid  = 1'b1;
        in_op     = op;
        in_index  = idx;
        in_tag    = tag;
        in_value  = val;
        out_ready = 1'b0;
        spur      = 1'($urandom_range(1, 0));
        waited    = 0;
        while (!in_ready && waited < 20) begin
            @(negedge sys_clk);
            waited++;
        end
        check_output("accept_ready", 64'(in_ready), 64'd1);
        @(posedge sys_clk);
        @(negedge sys_clk);
        in_valid = 1'b0;
        spur     = 1'b0;
        in_op    = 2'($urandom);
        in_index = 12'($urandom);
        in_tag   = 16'($urandom);
        in_value = 31'($urandom);

        cyc = 1; rd_cnt = 0; rd_at = 0; wr_cnt = 0;
        got_wdata = '0; got_waddr = '0; ready_low = 1'b1;
        forever begin
            if (mem_rd_en) begin rd_cnt++; rd_at = cyc; end
            if (mem_wr_en) begin wr_cnt++; got_wdata = mem_wdata; got_waddr = mem_waddr; end
            if (in_ready) ready_low = 1'b0;
            if (out_valid || cyc >= 40) break;
            cyc++;
            @(negedge sys_clk);
        end
        check_output("out_valid", 64'(out_valid), 64'd1);
        check_output("latency", 64'(cyc), 64'(e_lat));
        check_output("rd_en_count", 64'(rd_cnt), (op == 2'b11) ? 64'd0 : 64'd1);
        check_output("rd_en_cycle", 64'(rd_at), (op == 2'b11) ? 64'd0 : 64'd1);
        check_output("out_op", 64'(out_op), 64'(op));
        check_output("out_hit", 64'(out_hit), 64'(e_hit));
        check_output("out_evict", 64'(out_evict), 64'(e_evict));
        check_output("out_err", 64'(out_err), 64'(e_err));
        check_output("out_value", 64'(out_value), 64'(e_val));

        s_op = out_op; s_hit = out_hit; s_evict = out_evict; s_err = out_err; s_val = out_value;
        stable = 1'b1;
        repeat (hold) begin
            @(negedge sys_clk);
            if (mem_wr_en) wr_cnt++;
            if (in_ready) ready_low = 1'b0;
            if (!out_valid || out_op !== s_op || out_hit !== s_hit || out_evict !== s_evict ||
                out_err !== s_err || out_value !== s_val) stable = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge sys_clk);
        @(negedge sys_clk);
        out_ready = 1'b0;

        check_output("resp_stable", 64'(stable), 64'd1);
        check_output("in_ready_low", 64'(ready_low), 64'd1);
        check_output("out_valid_drop", 64'(out_valid), 64'd0);
        check_output("in_ready_back", 64'(in_ready), 64'd1);
        check_output("wr_en_count", 64'(wr_cnt), 64'(e_wr));
        if (e_wr) begin
            check_output("mem_wdata", 64'(got_wdata), 64'(e_wdata));
            check_output("mem_waddr", 64'(got_waddr), 64'(idx));
        end
        check_output("cnt_hit", 64'(cnt_hit), 64'(m_hits));
        check_output("cnt_miss", 64'(cnt_miss), 64'(m_misses));
    endtask

    // Reset lands while a SET waits on a slow read: nothing may reach the RAM or the response port.
    task automatic reset_mid_set(input logic [AW-1:0] idx, input logic [TW-1:0] tag);
        int wr_cnt, ov_cnt;
        ram_lat = 4;
        @(negedge sys_clk);
        in_valid = 1'b1;
        in_op    = 2'b01;
        in_index = idx;
        in_tag   = tag;
        in_value = 31'h1;
        @(posedge sys_clk);
        @(negedge sys_clk);
        in_valid = 1'b0;
        check_output("rst_rd_en", 64'(mem_rd_en), 64'd1);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        wr_cnt = 0; ov_cnt = 0;
        repeat (4) begin
            @(negedge sys_clk);
            if (mem_wr_en) wr_cnt++;
            if (out_valid) ov_cnt++;
        end
        sys_rst  = 1'b1;
        m_hits   = 0;
        m_misses = 0;
        repeat (6) begin
            @(negedge sys_clk);
            if (mem_wr_en) wr_cnt++;
            if (out_valid) ov_cnt++;
        end
        check_output("rst_no_write", 64'(wr_cnt), 64'd0);
        check_output("rst_no_resp", 64'(ov_cnt), 64'd0);
        check_output("rst_cnt_hit", 64'(cnt_hit), 64'd0);
        check_output("rst_cnt_miss", 64'(cnt_miss), 64'd0);
        check_output("rst_in_ready", 64'(in_ready), 64'd1);
        ram_lat = 0;
    endtask

    initial begin
        logic [1:0]    r_op;
        logic [AW-1:0] r_idx;
        logic [TW-1:0] r_tag;
        logic [VW-1:0] r_val;

        for (int i = 0; i < 4096; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = '0;
            m_val[i]   = '0;
        end
        sys_rst   = 1'b0;
        in_valid  = 1'b0;
        in_op     = '0;
        in_index  = '0;
        in_tag    = '0;
        in_value  = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge sys_clk);

        check_output("reset_in_ready", 64'(in_ready), 64'd1);
        check_output("reset_out_valid", 64'(out_valid), 64'd0);
        check_output("reset_flags", 64'({out_hit, out_evict, out_err, mem_rd_en, mem_wr_en}), 64'd0);
        check_output("reset_out_fields", 64'({out_op, out_value}), 64'd0);
        check_output("reset_mem_addr", 64'({mem_raddr, mem_waddr}), 64'd0);
        check_output("reset_mem_wdata", 64'(mem_wdata), 64'd0);
        check_output("reset_mem_wmask", 64'(mem_wmask), 64'd0);
        check_output("reset_counters", {cnt_hit, cnt_miss}, 64'd0);
        sys_rst = 1'b1;

        apply_stimulus(2'b00, 12'h005, 16'h1234, 31'h0, 0, 0);
        apply_stimulus(2'b01, 12'h005, 16'h1234, 31'h0ABCDEF, 0, 0);
        apply_stimulus(2'b00, 12'h005, 16'h1234, 31'h0, 0, 0);
        apply_stimulus(2'b01, 12'h005, 16'h9999, 31'h7, 0, 0);
        apply_stimulus(2'b00, 12'h005, 16'h1234, 31'h0, 0, 0);
        apply_stimulus(2'b00, 12'h005, 16'h9999, 31'h0, 0, 1);
        apply_stimulus(2'b10, 12'h005, 16'h1234, 31'h0, 0, 0);
        apply_stimulus(2'b10, 12'h005, 16'h9999, 31'h0, 0, 0);
        apply_stimulus(2'b00, 12'h005, 16'h9999, 31'h0, 0, 0);
        apply_stimulus(2'b01, 12'h010, 16'hBEEF, 31'h1234567, 10, 0);
        apply_stimulus(2'b11, 12'h020, 16'h0001, 31'h5, 2, 0);
        apply_stimulus(2'b00, 12'hFFF, 16'hFFFF, 31'h0, 0, 2);

        reset_mid_set(12'h030, 16'h4242);
        apply_stimulus(2'b00, 12'h030, 16'h4242, 31'h0, 0, 0);

        for (int n = 0; n < 200; n++) begin
            r_op  = 2'($urandom_range(3, 0));
            r_idx = 12'($urandom_range(7, 0));
            r_tag = 16'h1000 + 16'($urandom_range(2, 0));
            r_val = 31'($urandom);
            apply_stimulus(r_op, r_idx, r_tag, r_val, $urandom_range(3, 0), $urandom_range(2, 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
